// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter for the shared memory port with a hold-time watchdog.
// Optional MEM_ARB_CU_PRIORITY_EN: requester 0 (main CU) wins every idle arbitration it takes part in.
module memory_bus_arbiter #(
  parameter int p        = 4,
  parameter int MAX_HOLD = 256
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [p:0]             i_Request,
  output logic [p:0]             o_Grant,
  output logic [$clog2(p+1)-1:0] o_Owner,
  output logic                   o_Busy,
  output logic                   o_Timeout
);
  localparam int N  = p + 1;
  localparam int OW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   r_last, last_nx, owner_nx, winner;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [p:0]      grant_nx;
  logic            busy_nx, to_nx, found;
  int              idx;

  // Scan starts just past the last winner so the winner becomes lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_last) + k) % N;
      if (!found && i_Request[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
`ifdef MEM_ARB_CU_PRIORITY_EN
    if (i_Request[0]) winner = '0;
`endif
  end

  always_comb begin
    state_nx = state;
    last_nx  = r_last;
    owner_nx = o_Owner;
    cnt_nx   = cnt;
    grant_nx = o_Grant;
    busy_nx  = o_Busy;
    to_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nx         = '0;
          grant_nx[winner] = 1'b1;
          owner_nx         = winner;
          busy_nx          = 1'b1;
          last_nx          = winner;
          cnt_nx           = CW'(1);
          state_nx         = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!i_Request[o_Owner]) begin
          grant_nx = '0;
          busy_nx  = 1'b0;
          state_nx = S_TURN;
        end else if (cnt == CW'(MAX_HOLD)) begin
          grant_nx = '0;
          busy_nx  = 1'b0;
          to_nx    = 1'b1;
          state_nx = S_TURN;
        end else if (cnt != '1) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_TURN: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      r_last    <= OW'(p);
      o_Owner   <= '0;
      cnt       <= '0;
      o_Grant   <= '0;
      o_Busy    <= 1'b0;
      o_Timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      r_last    <= last_nx;
      o_Owner   <= owner_nx;
      cnt       <= cnt_nx;
      o_Grant   <= grant_nx;
      o_Busy    <= busy_nx;
      o_Timeout <= to_nx;
    end
  end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus random traffic against a bus-ownership model.
module tb_memory_bus_arbiter;
  localparam int P  = 4;
  localparam int N  = P + 1;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P:0]   req = '0;
  logic [P:0]   grant;
  logic [2:0]   owner;
  logic         busy, tmo;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.p(P), .MAX_HOLD(MH)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Request(req),
    .o_Grant(grant), .o_Owner(owner), .o_Busy(busy), .o_Timeout(tmo)
  );

  int tests = 0, fails = 0;

  // Model: who owns the bus, how long, cycles of mandatory bus-free time left, last winner.
  int m_owner = -1, m_hold = 0, m_cool = 0, m_last = P;
  bit m_to = 1'b0;
  int gseq[$];

  function automatic int pick(input logic [P:0] r, input int last);
`ifdef MEM_ARB_CU_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_cool = 0; m_last = P; m_to = 1'b0;
  endtask

  // Release leaves the bus free for two cycles before a new owner can appear.
  task automatic model_edge(input logic [P:0] r);
    int w;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_hold == MH) begin
        m_to    = r[m_owner];
        m_owner = -1;
        m_cool  = 1;
      end else m_hold++;
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_hold = 1;
        gseq.push_back(w);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [P:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, "_timeout"}, 32'(tmo), 32'(m_to));
    if (m_owner >= 0) chk({tag, "_owner"}, 32'(owner), 32'(m_owner));
  endtask

  task automatic step(input logic [P:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    chk_all(tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step('0, "drain");
  endtask

  initial begin
    int cyc, hcnt;
    logic [P:0] r;

    // 1: reset state, first grant, reset mid-grant
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_timeout", 32'(tmo), 0);
    @(posedge clk); #1; rst = 1'b0;
    step(5'b11111, "first");
    chk("first_grant0", 32'(grant), 32'h01);
    step(5'b11111, "hold");
    rst = 1'b1; #1;
    model_reset();
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    step(5'b11111, "post_rst");
    chk("post_rst_grant0", 32'(grant), 32'h01);
    drain();

    // 2: rotation with each owner dropping after 3 granted cycles
    model_reset();
    rst = 1'b1; #1; @(posedge clk); #1; rst = 1'b0;
    gseq.delete();
    cyc = 0;
    while (gseq.size() < 7 && cyc < 200) begin
      r = 5'b11111;
      if (m_owner >= 0 && m_hold >= 3) r[m_owner] = 1'b0;
      step(r, "rot");
      cyc++;
    end
    chk("rot_bound", 32'(gseq.size() >= 6), 1);
    for (int i = 0; i < 6 && i < gseq.size(); i++)
      chk($sformatf("rot_order%0d", i), 32'(gseq[i]), 32'(i % N));
    drain();

    // 3: single requester
    step(5'b00100, "single_req");
    chk("single_grant", 32'(grant), 32'h04);
    for (int i = 0; i < 3; i++) step(5'b00100, "single_hold");
    step('0, "single_drop");
    chk("single_drop_grant", 32'(grant), 0);
    chk("single_drop_busy", 32'(busy), 0);
    drain();

    // 4: watchdog on requester 3 with 4 also waiting
    step(5'b11000, "wd_req");
    chk("wd_first", 32'(owner), 3);
    hcnt = 0; cyc = 0;
    while (grant[3] && cyc < 50) begin
      hcnt++;
      step(5'b11000, "wd_hold");
      cyc++;
    end
    chk("wd_hold_cycles", 32'(hcnt), MH);
    chk("wd_pulse", 32'(tmo), 1);
    step(5'b11000, "wd_after");
    chk("wd_pulse_width", 32'(tmo), 0);
    cyc = 0;
    while (!busy && cyc < 10) begin step(5'b11000, "wd_wait"); cyc++; end
    chk("wd_next_owner", 32'(owner), 4);
    step('0, "wd_rel");
    drain();

    // 5: wrap from last winner 4 back to 0, then on to 4
    step(5'b10000, "wrap_pre");
    step('0, "wrap_pre_rel");
    drain();
    step(5'b10001, "wrap_req");
    chk("wrap_owner0", 32'(owner), 0);
    step(5'b10000, "wrap_drop0");
    step(5'b10001, "wrap_turn");
    step(5'b10001, "wrap_arb");
    chk("wrap_owner4", 32'(owner), 4);
    step('0, "wrap_rel");
    drain();

    // 6: last winner 0, requesters 0 and 1 contend
    step(5'b00001, "pri_pre");
    step('0, "pri_pre_rel");
    drain();
    step(5'b00011, "pri_req");
`ifdef MEM_ARB_CU_PRIORITY_EN
    chk("pri_owner", 32'(owner), 0);
`else
    chk("pri_owner", 32'(owner), 1);
`endif
    step('0, "pri_rel");
    drain();

    // random traffic; owners usually keep requesting so the watchdog fires too
    for (int i = 0; i < 600; i++) begin
      r = P'($urandom) | {1'b0, P'(0)};
      r = (P+1)'($urandom);
      if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 7) != 0);
      step(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
